// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALUOp encodings,
// FSM state encoding and the opcode legality helper.
package alu_arb_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLL: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester-facing bus of the ALU arbiter: two request channels and a shared
// response channel steered by a per-requester valid bit.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 64
);
    // Handshake: a transfer happens on a rising clk edge where valid[i] and
    // ready[i] are both 1; valid must not depend on ready, and the sender holds
    // its payload stable while valid is high and ready is low.
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [3:0]        req_op0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    logic [3:0]        req_op1;

    logic [1:0]        resp_valid;
    logic [1:0]        resp_ready;
    logic [DATA_W-1:0] resp_result;
    logic              resp_zero;
    logic              resp_sign;
    logic              resp_err;

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        output resp_ready,
        input  req_ready,
        input  resp_valid, resp_result, resp_zero, resp_sign, resp_err
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1,
        input  resp_ready,
        output req_ready,
        output resp_valid, resp_result, resp_zero, resp_sign, resp_err
    );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins; on contention the
// requester that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        case (req)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                grant    = last_grant ? 2'b01 : 2'b10;
                grant_id = ~last_grant;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, one op in flight.
// Define ALU_ARB_OPCHK_EN to flag illegal ALUOps through resp_err.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_share_arbiter_if.slave bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_sign,
    output logic [CNT_W-1:0]  op_count,
    output state_t            dbg_state
);

    state_t     state;
    logic       last_grant;
    logic       grant_id;
    logic [1:0] pick;
    logic       pick_id;
    logic       op_bad;

    rr_arb2 u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (pick),
        .grant_id   (pick_id)
    );

    assign bus.req_ready = (state == IDLE) ? pick : 2'b00;
    assign dbg_state     = state;

`ifdef ALU_ARB_OPCHK_EN
    assign op_bad = ~op_legal(alu_op);
`else
    assign op_bad = 1'b0;
`endif

    // alu_a/alu_b/alu_op double as the operand registers; they hold outside EXEC.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            last_grant      <= 1'b1;
            grant_id        <= 1'b0;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_op          <= OP_AND;
            bus.resp_valid  <= 2'b00;
            bus.resp_result <= '0;
            bus.resp_zero   <= 1'b0;
            bus.resp_sign   <= 1'b0;
            bus.resp_err    <= 1'b0;
            op_count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|(bus.req_valid & bus.req_ready)) begin
                        alu_a      <= pick_id ? bus.req_a1  : bus.req_a0;
                        alu_b      <= pick_id ? bus.req_b1  : bus.req_b0;
                        alu_op     <= pick_id ? bus.req_op1 : bus.req_op0;
                        grant_id   <= pick_id;
                        last_grant <= pick_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_bad) begin
                        bus.resp_result <= '0;
                        bus.resp_zero   <= 1'b0;
                        bus.resp_sign   <= 1'b0;
                        bus.resp_err    <= 1'b1;
                    end else begin
                        bus.resp_result <= alu_result;
                        bus.resp_zero   <= alu_zero;
                        // The ALU's sign output is only meaningful for SUB.
                        bus.resp_sign   <= (alu_op == OP_SUB) & alu_sign;
                        bus.resp_err    <= 1'b0;
                    end
                    op_count       <= op_count + CNT_W'(1);
                    bus.resp_valid <= grant_id ? 2'b10 : 2'b01;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready[grant_id]) begin
                        bus.resp_valid <= 2'b00;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a reference ALU and a second,
// narrow-counter instance used to observe op_count wrap.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic w_reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  alu_share_arbiter_if #(.DATA_W(DATA_W)) bus ();
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [3:0]        alu_op;
  logic              alu_zero, alu_sign;
  logic [CNT_W-1:0]  op_count;
  state_t            dbg_state;

  alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_sign   (alu_sign),
    .op_count   (op_count),
    .dbg_state  (dbg_state)
  );

  // reference ALU; sign is raw result[63] for every op
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SLL:  alu_result = alu_a << alu_b[5:0];
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == '0);
    alu_sign = alu_result[63];
  end

  // ---------------- narrow-counter instance ----------------
  alu_share_arbiter_if #(.DATA_W(DATA_W)) wbus ();
  logic [DATA_W-1:0] w_alu_a, w_alu_b;
  logic [3:0]        w_alu_op;
  logic [1:0]        w_count;
  state_t            w_state;

  alu_share_arbiter #(.DATA_W(DATA_W), .CNT_W(2)) dut_wrap (
    .clk        (clk),
    .reset_n    (w_reset_n),
    .bus        (wbus),
    .alu_a      (w_alu_a),
    .alu_b      (w_alu_b),
    .alu_op     (w_alu_op),
    .alu_result (64'd0),
    .alu_zero   (1'b1),
    .alu_sign   (1'b0),
    .op_count   (w_count),
    .dbg_state  (w_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.req_valid  = 2'b00;
    bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = 4'd0;
    bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = 4'd0;
    bus.resp_ready = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] op);
    if (id == 0) begin
      bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op; bus.req_valid[0] = 1'b1;
    end else begin
      bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op; bus.req_valid[1] = 1'b1;
    end
  endtask

  // returns on the falling edge of the EXEC cycle
  task automatic issue(input string tag, input int id, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] op);
    set_req(id, a, b, op);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready[id]) break;
      @(negedge clk); #1;
    end
    check({tag, "_rdy"}, 64'(bus.req_ready), (id == 0) ? 64'd1 : 64'd2);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
  endtask

  task automatic wait_resp(input string tag, input int id);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.resp_valid[id]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, 64'(ok), 64'd1);
  endtask

  task automatic check_resp(input string tag, input int id, input logic zero,
                            input logic sign, input logic err, input logic [15:0] cnt);
    logic [63:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
    check({tag, "_vld"},  64'(bus.resp_valid), (id == 0) ? 64'd1 : 64'd2);
    check({tag, "_res"},  bus.resp_result, e);
    check({tag, "_zero"}, 64'(bus.resp_zero), 64'(zero));
    check({tag, "_sign"}, 64'(bus.resp_sign), 64'(sign));
    check({tag, "_err"},  64'(bus.resp_err), 64'(err));
    check({tag, "_cnt"},  64'(op_count), 64'(cnt));
  endtask

  task automatic finish_resp(input string tag, input int id);
    bus.resp_ready[id] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready[id] = 1'b0;
    check({tag, "_drop"}, 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"},   64'(bus.req_ready), 64'd0);
    check({tag, "_vld"},   64'(bus.resp_valid), 64'd0);
    check({tag, "_res"},   bus.resp_result, 64'd0);
    check({tag, "_zero"},  64'(bus.resp_zero), 64'd0);
    check({tag, "_sign"},  64'(bus.resp_sign), 64'd0);
    check({tag, "_err"},   64'(bus.resp_err), 64'd0);
    check({tag, "_a"},     alu_a, 64'd0);
    check({tag, "_b"},     alu_b, 64'd0);
    check({tag, "_op"},    64'(alu_op), 64'd0);
    check({tag, "_cnt"},   64'(op_count), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int w_n;
    logic [63:0] e;
    logic exp_id;

    wbus.req_valid = 2'b01;
    wbus.req_a0 = '0; wbus.req_b0 = '0; wbus.req_op0 = OP_ADD;
    wbus.req_a1 = '0; wbus.req_b1 = '0; wbus.req_op1 = OP_ADD;
    wbus.resp_ready = 2'b01;

    // reset values
    clear_inputs();
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    // single request: 5 + 7
    exp_q.push_back(64'd12);
    issue("single", 0, 64'd5, 64'd7, OP_ADD);
    check("single_state", 64'(dbg_state), 64'(EXEC));
    check("single_alu_a", alu_a, 64'd5);
    check("single_alu_b", alu_b, 64'd7);
    check("single_exec_rdy", 64'(bus.req_ready), 64'd0);
    check("single_exec_vld", 64'(bus.resp_valid), 64'd0);
    @(negedge clk);
    check_resp("single", 0, 1'b0, 1'b0, 1'b0, 16'd1);
    finish_resp("single", 0);

    // contention: both valid, responses always accepted
    do_reset();
    bus.req_a0 = 64'd10; bus.req_b0 = 64'd20; bus.req_op0 = OP_ADD;
    bus.req_a1 = 64'd3;  bus.req_b1 = 64'd5;  bus.req_op1 = OP_SUB;
    bus.req_valid  = 2'b11;
    bus.resp_ready = 2'b11;
    exp_q.push_back(64'd30);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    exp_q.push_back(64'd30);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
    k = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.resp_valid != 2'b00) begin
        exp_id = k[0];
        k++;
        check_resp("cont", int'(exp_id), 1'b0, exp_id, 1'b0, 16'(k));
      end
    end
    check("cont_count", 64'(k), 64'd4);
    clear_inputs();

    // backpressure with zero result; requester 1 waits meanwhile
    do_reset();
    set_req(1, 64'd1, 64'd1, OP_ADD);
    exp_q.push_back(64'd0);
    issue("bp", 0, 64'd9, 64'd9, OP_SUB);
    wait_resp("bp", 0);
    e = exp_q.pop_front();
    bus.resp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      check("bp_vld",  64'(bus.resp_valid), 64'd1);
      check("bp_res",  bus.resp_result, e);
      check("bp_zero", 64'(bus.resp_zero), 64'd1);
      check("bp_sign", 64'(bus.resp_sign), 64'd0);
      check("bp_rdy",  64'(bus.req_ready), 64'd0);
      @(negedge clk);
    end
    bus.resp_ready = 2'b00;
    bus.req_valid  = 2'b00;
    finish_resp("bp", 0);

    // sign masking: SUB keeps sign, OR with result[63]=1 does not
    do_reset();
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    issue("sub", 0, 64'd1, 64'd2, OP_SUB);
    wait_resp("sub", 0);
    check_resp("sub", 0, 1'b0, 1'b1, 1'b0, 16'd1);
    finish_resp("sub", 0);
    exp_q.push_back(64'h8000_0000_0000_0000);
    issue("or", 0, 64'h8000_0000_0000_0000, 64'd0, OP_OR);
    wait_resp("or", 0);
    check_resp("or", 0, 1'b0, 1'b0, 1'b0, 16'd2);
    finish_resp("or", 0);

    // opcode 0011: flagged when the checker is built in, passed through otherwise
`ifdef ALU_ARB_OPCHK_EN
    exp_q.push_back(64'd0);
    issue("ill", 1, 64'd6, 64'd3, 4'b0011);
    wait_resp("ill", 1);
    check_resp("ill", 1, 1'b0, 1'b0, 1'b1, 16'd3);
`else
    exp_q.push_back(64'd5);
    issue("ill", 1, 64'd6, 64'd3, 4'b0011);
    wait_resp("ill", 1);
    check_resp("ill", 1, 1'b0, 1'b0, 1'b0, 16'd3);
`endif
    finish_resp("ill", 1);

    // remaining ALU ops
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    issue("nor", 1, 64'd0, 64'd0, OP_NOR);
    wait_resp("nor", 1);
    check_resp("nor", 1, 1'b0, 1'b0, 1'b0, 16'd4);
    finish_resp("nor", 1);
    exp_q.push_back(64'd16);
    issue("sll", 0, 64'd1, 64'd4, OP_SLL);
    wait_resp("sll", 0);
    check_resp("sll", 0, 1'b0, 1'b0, 1'b0, 16'd5);
    finish_resp("sll", 0);
    exp_q.push_back(64'd0);
    issue("and", 1, 64'hF0, 64'h0F, OP_AND);
    wait_resp("and", 1);
    check_resp("and", 1, 1'b1, 1'b0, 1'b0, 16'd6);
    finish_resp("and", 1);

    // reset during EXEC discards the op
    issue("mid", 1, 64'd7, 64'd7, OP_ADD);
    reset_n = 1'b0;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    check("rst_mid_hold_vld", 64'(bus.resp_valid), 64'd0);
    reset_n = 1'b1;
    bus.req_a0 = 64'd1; bus.req_b0 = 64'd1; bus.req_op0 = OP_ADD;
    bus.req_a1 = 64'd2; bus.req_b1 = 64'd2; bus.req_op1 = OP_ADD;
    bus.req_valid = 2'b11;
    #1;
    check("post_rst_rdy", 64'(bus.req_ready), 64'd1);
    exp_q.push_back(64'd2);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_resp("post_rst", 0);
    check_resp("post_rst", 0, 1'b0, 1'b0, 1'b0, 16'd1);
    finish_resp("post_rst", 0);

    // op_count wrap on the 2-bit counter instance
    w_reset_n = 1'b1;
    w_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (wbus.resp_valid[0]) begin
        w_n++;
        check("wrap_cnt", 64'(w_count), 64'(w_n % 4));
      end
    end
    check("wrap_ops", 64'(w_n), 64'd13);
    check("wrap_q_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
